pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and the instruction-memory address. Each cycle it chooses the next PC from sequential, branch or jump sources, and supplies the IF/ID register with `pc_4`, its load enable and its bubble/clear request. A two-state run/halt controller stops fetch on a syscall halt and resumes it on an operator `go` pulse. A fetch counter is exposed for the debug display.

## Interface
- `PC_WIDTH`, 12, width of PC and instruction-memory byte address (4 KiB space)
- `RESET_PC`, 12'h000, PC value loaded by reset; must be word-aligned
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `stall`  in  1  hazard unit: hold PC and IF/ID contents
- `branch_taken`  in  1  branch resolved taken this cycle
- `branch_target`  in  PC_WIDTH  branch destination byte address
- `jump`  in  1  J/JAL/JR redirect this cycle
- `jump_target`  in  PC_WIDTH  jump destination byte address
- `halt_req`  in  1  syscall-halt decoded downstream
- `go`  in  1  resume pulse (operator button, already debounced)
- `imem_addr`  out  PC_WIDTH  current PC to instruction memory
- `pc_4`  out  PC_WIDTH  PC+4 (mod 2^PC_WIDTH), to IF/ID `pc_4`
- `if_go`  out  1  IF/ID load enable
- `flush`  out  1  IF/ID clear: load a zero bubble
- `halted`  out  1  controller in HALT
- `fetch_count`  out  32  count of PC updates since reset, saturating

## Operation
- State register: RUN, HALT. Reset enters RUN with `pc = RESET_PC` and `fetch_count = 0`.
- Next-PC priority in RUN, highest first:
  1. `halt_req`: enter HALT, PC holds, `if_go=0`, `flush=0`; any simultaneous redirect is discarded.
  2. `jump`: `pc <= jump_target & ~3`.
  3. `branch_taken`: `pc <= branch_target & ~3`.
  4. `stall`: PC holds.
  5. Otherwise: `pc <= pc + 4`, wrapping modulo 2^PC_WIDTH (0xFFC → 0x000).
- A redirect (priority 2 or 3) overrides `stall`, asserts `flush=1` and `if_go=1`, so the wrong-path instruction becomes a zero bubble.
- Sequential advance: `if_go=1`, `flush=0`. During a stall: `if_go=0`, `flush=0`.
- HALT: PC holds; `if_go=0`, `flush=0`, `halted=1`. `halt_req`, `jump`, `branch_taken` and `stall` are ignored. `go=1` returns to RUN on the next edge with the PC unchanged, and fetch resumes at the held PC.
- `go` in RUN has no effect.
- `fetch_count` increments on every edge where the PC register is written (sequential or redirect), including a redirect whose target equals the current PC. It saturates at 0xFFFF_FFFF.
- `imem_addr = pc`. `pc_4` is `pc + 4` truncated to PC_WIDTH.

## Timing
- Reset (`rst_n=0` at an edge) has priority over everything, including mid-HALT and mid-redirect. While `rst_n=0`: `if_go=0`, `flush=0`.
- Values after reset: `imem_addr=RESET_PC`, `pc_4=RESET_PC+4`, `halted=0`, `fetch_count=0`.
- `pc`, state and `fetch_count` are registered. `if_go` and `flush` are combinational from the current state and inputs, valid in the same cycle, and sampled by IF/ID at the same edge that updates the PC.
- Fetch latency: the address appears on `imem_addr` one edge after selection. Instruction memory reads combinationally, so IF/ID captures that instruction at the following edge.
- Redirect penalty: one bubble. `halt_req` to `halted=1`: one edge. `go` to the first fetch (`if_go=1`): one edge.

## Test plan
- Reset then 4 free cycles: `imem_addr` goes 0x000, 0x004, 0x008, 0x00C. `pc_4` is always addr+4. `if_go=1` and `fetch_count=4` at the end.
- Stall for 2 cycles at 0x010, then release: `imem_addr` stays at 0x010 for 3 cycles with `if_go=0` during the stall, then 0x014. `fetch_count` does not change during the stall.
- `branch_taken`, `branch_target=0x123` together with `stall=1`: `flush=1` and `if_go=1` that cycle. Next `imem_addr=0x120`.
- `jump` to 0x200 and `branch_taken` to 0x300 in the same cycle: next `imem_addr=0x200`.
- `halt_req` together with `jump`: `halted=1` and the PC is held. 5 cycles of redirects are ignored. `go` gives `halted=0` next cycle and fetch resumes at the held PC.
- Start at PC 0xFFC: `pc_4=0x000` and the next `imem_addr=0x000`. Assert `rst_n=0` while in HALT: `halted=0`, `imem_addr=RESET_PC`.

Source files
------------

// File: rtl/pc_fetch.sv
// ============================================================================
// pc_fetch : MIPS IF stage - program counter, next-PC select, run/halt control
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch #(
    parameter int                    PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = 12'h000
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    input  logic                jump_i,
    input  logic [PC_WIDTH-1:0] jump_target_i,
    input  logic                halt_req_i,
    input  logic                go_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    output logic [PC_WIDTH-1:0] pc_4_o,
    output logic                if_go_o,
    output logic                flush_o,
    output logic                halted_o,
    output logic [31:0]         fetch_count_o
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus4;
    logic [31:0]         fetch_count_q, fetch_count_d;
    logic                pc_we;

    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    // State, PC and fetch counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_count_q <= fetch_count_d;
            if (pc_we) begin
                pc_q <= pc_d;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (halt_req_i) state_d = S_HALT;
            S_HALT:  if (go_i)       state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Output / next-PC logic; redirects are forced to word alignment
    always_comb begin
        pc_d    = pc_q;
        pc_we   = 1'b0;
        if_go_o = 1'b0;
        flush_o = 1'b0;
        if (rst_n_i && state_q == S_RUN && !halt_req_i) begin
            if (jump_i) begin
                pc_d    = {jump_target_i[PC_WIDTH-1:2], 2'b00};
                pc_we   = 1'b1;
                if_go_o = 1'b1;
                flush_o = 1'b1;
            end else if (branch_taken_i) begin
                pc_d    = {branch_target_i[PC_WIDTH-1:2], 2'b00};
                pc_we   = 1'b1;
                if_go_o = 1'b1;
                flush_o = 1'b1;
            end else if (!stall_i) begin
                pc_d    = pc_plus4;
                pc_we   = 1'b1;
                if_go_o = 1'b1;
            end
        end
    end

    assign fetch_count_d = (pc_we && fetch_count_q != 32'hFFFF_FFFF)
                         ? fetch_count_q + 32'd1 : fetch_count_q;

    assign imem_addr_o   = pc_q;
    assign pc_4_o        = pc_plus4;
    assign halted_o      = (state_q == S_HALT);
    assign fetch_count_o = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// tb_pc_fetch : directed self-checking bench for pc_fetch
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken, jump, halt_req, go;
    logic [11:0] branch_target, jump_target;
    logic [11:0] imem_addr, pc_4;
    logic        if_go, flush, halted;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch #(.PC_WIDTH(12), .RESET_PC(12'h000)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .halt_req_i      (halt_req),
        .go_i            (go),
        .imem_addr_o     (imem_addr),
        .pc_4_o          (pc_4),
        .if_go_o         (if_go),
        .flush_o         (flush),
        .halted_o        (halted),
        .fetch_count_o   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jump = 0; halt_req = 0; go = 0;
        branch_target = 12'h000; jump_target = 12'h000;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        tick(); tick();
        n_checks++; if (imem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h exp 000", imem_addr); end
        n_checks++; if (pc_4 !== 12'h004) begin n_fail++; $display("FAIL reset_pc4: got %h exp 004", pc_4); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b exp 0", halted); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", fetch_count); end
        n_checks++; if (if_go !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: got if_go=%b flush=%b exp 0/0", if_go, flush); end
        rst_n = 1;
        #1;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (imem_addr !== 12'(4*k) || pc_4 !== 12'(4*k+4)) begin n_fail++; $display("FAIL seq_addr[%0d]: got addr=%h pc4=%h exp %h/%h", k, imem_addr, pc_4, 12'(4*k), 12'(4*k+4)); end
            n_checks++; if (if_go !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL seq_ctl[%0d]: got if_go=%b flush=%b exp 1/0", k, if_go, flush); end
            tick();
        end
        n_checks++; if (fetch_count !== 32'd4 || imem_addr !== 12'h010) begin n_fail++; $display("FAIL seq_end: got count=%0d addr=%h exp 4/010", fetch_count, imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (imem_addr !== 12'h010 || if_go !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL stall[%0d]: got addr=%h if_go=%b flush=%b exp 010/0/0", k, imem_addr, if_go, flush); end
            tick();
            n_checks++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d exp 4", k, fetch_count); end
        end
        stall = 0;
        #1;
        n_checks++; if (imem_addr !== 12'h010 || if_go !== 1'b1) begin n_fail++; $display("FAIL stall_release: got addr=%h if_go=%b exp 010/1", imem_addr, if_go); end
        tick();
        n_checks++; if (imem_addr !== 12'h014 || fetch_count !== 32'd5) begin n_fail++; $display("FAIL stall_resume: got addr=%h count=%0d exp 014/5", imem_addr, fetch_count); end
    endtask

    task automatic test_branch_over_stall();
        stall = 1; branch_taken = 1; branch_target = 12'h123;
        #1;
        n_checks++; if (flush !== 1'b1 || if_go !== 1'b1) begin n_fail++; $display("FAIL branch_ctl: got flush=%b if_go=%b exp 1/1", flush, if_go); end
        tick();
        clear_inputs();
        n_checks++; if (imem_addr !== 12'h120 || fetch_count !== 32'd6) begin n_fail++; $display("FAIL branch_addr: got addr=%h count=%0d exp 120/6", imem_addr, fetch_count); end
    endtask

    task automatic test_jump_priority();
        jump = 1; jump_target = 12'h200; branch_taken = 1; branch_target = 12'h300;
        #1;
        n_checks++; if (flush !== 1'b1 || if_go !== 1'b1) begin n_fail++; $display("FAIL jump_ctl: got flush=%b if_go=%b exp 1/1", flush, if_go); end
        tick();
        clear_inputs();
        n_checks++; if (imem_addr !== 12'h200 || fetch_count !== 32'd7) begin n_fail++; $display("FAIL jump_addr: got addr=%h count=%0d exp 200/7", imem_addr, fetch_count); end
        // redirect onto the current PC still counts as a PC write
        jump = 1; jump_target = 12'h200;
        tick();
        clear_inputs();
        n_checks++; if (imem_addr !== 12'h200 || fetch_count !== 32'd8) begin n_fail++; $display("FAIL jump_self: got addr=%h count=%0d exp 200/8", imem_addr, fetch_count); end
    endtask

    task automatic test_halt();
        halt_req = 1; jump = 1; jump_target = 12'h040;
        #1;
        n_checks++; if (if_go !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL halt_req_ctl: got if_go=%b flush=%b exp 0/0", if_go, flush); end
        tick();
        clear_inputs();
        n_checks++; if (halted !== 1'b1 || imem_addr !== 12'h200 || fetch_count !== 32'd8) begin n_fail++; $display("FAIL halt_enter: got halted=%b addr=%h count=%0d exp 1/200/8", halted, imem_addr, fetch_count); end
        for (int k = 0; k < 5; k++) begin
            jump = (k % 2 == 0); jump_target = 12'h300;
            branch_taken = 1; branch_target = 12'h400;
            halt_req = (k == 1); stall = (k == 3);
            #1;
            n_checks++; if (if_go !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL halt_ctl[%0d]: got if_go=%b flush=%b exp 0/0", k, if_go, flush); end
            tick();
            n_checks++; if (halted !== 1'b1 || imem_addr !== 12'h200) begin n_fail++; $display("FAIL halt_hold[%0d]: got halted=%b addr=%h exp 1/200", k, halted, imem_addr); end
        end
        clear_inputs();
        go = 1;
        tick();
        go = 0;
        #1;
        n_checks++; if (halted !== 1'b0 || imem_addr !== 12'h200 || if_go !== 1'b1) begin n_fail++; $display("FAIL halt_go: got halted=%b addr=%h if_go=%b exp 0/200/1", halted, imem_addr, if_go); end
        tick();
        n_checks++; if (imem_addr !== 12'h204 || fetch_count !== 32'd9) begin n_fail++; $display("FAIL halt_resume: got addr=%h count=%0d exp 204/9", imem_addr, fetch_count); end
    endtask

    task automatic test_go_in_run();
        go = 1;
        tick();
        go = 0;
        n_checks++; if (halted !== 1'b0 || imem_addr !== 12'h208 || fetch_count !== 32'd10) begin n_fail++; $display("FAIL go_run: got halted=%b addr=%h count=%0d exp 0/208/10", halted, imem_addr, fetch_count); end
    endtask

    task automatic test_wrap_and_reset_in_halt();
        jump = 1; jump_target = 12'hFFF;
        tick();
        clear_inputs();
        n_checks++; if (imem_addr !== 12'hFFC || pc_4 !== 12'h000) begin n_fail++; $display("FAIL wrap_pc4: got addr=%h pc4=%h exp FFC/000", imem_addr, pc_4); end
        tick();
        n_checks++; if (imem_addr !== 12'h000 || fetch_count !== 32'd12) begin n_fail++; $display("FAIL wrap_addr: got addr=%h count=%0d exp 000/12", imem_addr, fetch_count); end
        tick();
        halt_req = 1;
        tick();
        halt_req = 0;
        n_checks++; if (halted !== 1'b1 || imem_addr !== 12'h004) begin n_fail++; $display("FAIL rst_halt_pre: got halted=%b addr=%h exp 1/004", halted, imem_addr); end
        rst_n = 0; go = 1; jump = 1; jump_target = 12'h500;
        #1;
        n_checks++; if (if_go !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL rst_halt_ctl: got if_go=%b flush=%b exp 0/0", if_go, flush); end
        tick();
        clear_inputs();
        n_checks++; if (halted !== 1'b0 || imem_addr !== 12'h000 || fetch_count !== 32'd0) begin n_fail++; $display("FAIL rst_halt: got halted=%b addr=%h count=%0d exp 0/000/0", halted, imem_addr, fetch_count); end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_over_stall();
        test_jump_priority();
        test_halt();
        test_go_in_run();
        test_wrap_and_reset_in_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
